// File: rtl/programmable_timer_if.sv
// Bus bundle for programmable_timer.
// The master side drives the control inputs; the slave side (the timer) drives the status outputs.
interface programmable_timer_if #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
);
   logic             Load;
   logic [WIDTH-1:0] LoadVal;
   logic [PRE_W-1:0] Prescale;
   logic             Mode;
   logic             Pause;
   logic             Ack;
   logic [WIDTH-1:0] Count;
   logic             Busy;
   logic             Tick;
   logic             Done;

   modport master (
      output Load, LoadVal, Prescale, Mode, Pause, Ack,
      input  Count, Busy, Tick, Done
   );

   modport slave (
      input  Load, LoadVal, Prescale, Mode, Pause, Ack,
      output Count, Busy, Tick, Done
   );
endinterface

// File: rtl/programmable_timer.sv
// Prescaled down-counter with one-shot or auto-reload modes, pause, and a sticky Done flag.
// Tick is a registered one-cycle pulse issued at each terminal count.
module programmable_timer #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   programmable_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, lval_q, lval_d;
   logic [PRE_W-1:0] pre_q, pre_d, lpre_q, lpre_d;
   logic             mode_q, mode_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             zpend_q, zpend_d;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         lval_q  <= '0;
         lpre_q  <= '0;
         mode_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         zpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         lval_q  <= lval_d;
         lpre_q  <= lpre_d;
         mode_q  <= mode_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         zpend_q <= zpend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      lval_d  = lval_q;
      lpre_d  = lpre_q;
      mode_d  = mode_q;
      tick_d  = 1'b0;
      done_d  = done_q & ~bus.Ack;
      zpend_d = 1'b0;
      if (bus.Load) begin
         cnt_d  = bus.LoadVal;
         pre_d  = '0;
         done_d = 1'b0;
         lval_d = bus.LoadVal;
         lpre_d = bus.Prescale;
         mode_d = bus.Mode;
         if (bus.LoadVal == '0) begin
            // Zero load expires immediately; its Tick/Done land one cycle later.
            state_d = EXPIRED;
            mode_d  = 1'b0;
            zpend_d = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else begin
         case (state_q)
            RUN, PAUSED: begin
               if (bus.Pause) begin
                  state_d = PAUSED;
               end else begin
                  // Leaving PAUSED counts on the same edge so no cycle is lost.
                  state_d = RUN;
                  if (pre_q == lpre_q) begin
                     pre_d = '0;
                     if (cnt_q == WIDTH'(1)) begin
                        tick_d = 1'b1;
                        done_d = 1'b1;
                        if (mode_q) begin
                           cnt_d = lval_q;
                        end else begin
                           cnt_d   = '0;
                           state_d = EXPIRED;
                        end
                     end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                     end
                  end else begin
                     pre_d = pre_q + PRE_W'(1);
                  end
               end
            end
            EXPIRED: begin
               if (zpend_q) begin
                  tick_d = 1'b1;
                  done_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Count = cnt_q;
   assign bus.Busy  = (state_q == RUN) || (state_q == PAUSED);
   assign bus.Tick  = tick_q;
   assign bus.Done  = done_q;
endmodule

// File: tb/tb_programmable_timer.sv
// Directed bench for programmable_timer: 8-bit instance for function, 16-bit instance for full-range count.
// Inputs change and outputs are sampled at the falling edge.
module tb_programmable_timer;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 Clk = ~Clk;

   programmable_timer_if #(.WIDTH(8),  .PRE_W(4)) bus8 ();
   programmable_timer_if #(.WIDTH(16), .PRE_W(4)) bus16 ();

   programmable_timer #(.WIDTH(8),  .PRE_W(4)) dut8  (.Clk(Clk), .Rst(Rst), .bus(bus8));
   programmable_timer #(.WIDTH(16), .PRE_W(4)) dut16 (.Clk(Clk), .Rst(Rst), .bus(bus16));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge Clk);
   endtask

   // Count/Busy/Tick/Done of the 8-bit instance in one go
   task automatic chk8(input string tag, input int cnt, input bit busy, input bit tick, input bit done);
      chk({tag, ".cnt"},  32'(bus8.Count), 32'(cnt));
      chk({tag, ".busy"}, 32'(bus8.Busy),  32'(busy));
      chk({tag, ".tick"}, 32'(bus8.Tick),  32'(tick));
      chk({tag, ".done"}, 32'(bus8.Done),  32'(done));
   endtask

   task automatic load8(input logic [7:0] v, input logic [3:0] p, input bit m);
      bus8.Load = 1'b1; bus8.LoadVal = v; bus8.Prescale = p; bus8.Mode = m;
      step();
      bus8.Load = 1'b0;
   endtask

   initial begin
      bus8.Load = 0;  bus8.LoadVal = 0;  bus8.Prescale = 0;  bus8.Mode = 0;  bus8.Pause = 0;  bus8.Ack = 0;
      bus16.Load = 0; bus16.LoadVal = 0; bus16.Prescale = 0; bus16.Mode = 0; bus16.Pause = 0; bus16.Ack = 0;
      step(2);
      chk8("rst", 0, 0, 0, 0);
      Rst = 1'b0;
      step(2);
      chk8("idle", 0, 0, 0, 0);

      // one-shot 5, prescale 0
      load8(8'd5, 4'd0, 1'b0);
      for (int i = 5; i >= 1; i--) begin
         chk8($sformatf("os%0d", i), i, 1, 0, 0);
         step();
      end
      chk8("os_term", 0, 0, 1, 1);
      step();
      chk8("os_hold", 0, 0, 0, 1);
      bus8.Pause = 1'b1;            // no effect in EXPIRED
      step();
      bus8.Pause = 1'b0;
      chk8("os_pause", 0, 0, 0, 1);

      // auto-reload 3, prescale 2: period 9
      load8(8'd3, 4'd2, 1'b1);
      chk8("ar_k", 3, 1, 0, 0);
      step(8);
      chk8("ar_k8", 1, 1, 0, 0);
      step();
      chk8("ar_k9", 3, 1, 1, 1);
      step();
      chk8("ar_k10", 3, 1, 0, 1);
      step(7);
      chk8("ar_k17", 1, 1, 0, 1);
      step();
      chk8("ar_k18", 3, 1, 1, 1);
      bus8.Ack = 1'b1;
      step();
      bus8.Ack = 1'b0;
      chk8("ar_ack", 3, 1, 0, 0);

      // pause for 3 cycles delays terminal count by 3
      load8(8'd4, 4'd0, 1'b0);
      step();
      chk8("pz_k1", 3, 1, 0, 0);
      bus8.Pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk8($sformatf("pz_hold%0d", i), 3, 1, 0, 0);
      end
      bus8.Pause = 1'b0;
      step();
      chk8("pz_k5", 2, 1, 0, 0);
      step();
      chk8("pz_k6", 1, 1, 0, 0);
      step();
      chk8("pz_k7", 0, 0, 1, 1);

      // zero load: EXPIRED now, Tick/Done one cycle later
      load8(8'd0, 4'd5, 1'b1);
      chk8("z_k", 0, 0, 0, 0);
      step();
      chk8("z_k1", 0, 0, 1, 1);
      step();
      chk8("z_k2", 0, 0, 0, 1);
      load8(8'd0, 4'd0, 1'b0);
      chk8("z2_k", 0, 0, 0, 0);
      bus8.Ack = 1'b1;              // Ack coincides with Done-set: set wins
      step();
      chk8("z2_ack", 0, 0, 1, 1);

      // LoadVal=1, Prescale=0, auto-reload: Tick every cycle, Ack can't clear Done
      bus8.Ack = 1'b0;
      load8(8'd1, 4'd0, 1'b1);
      chk8("t1_k", 1, 1, 0, 0);
      bus8.Ack = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk8($sformatf("t1_k%0d", i), 1, 1, 1, 1);
      end
      bus8.Ack = 1'b0;

      // asynchronous reset mid-count
      load8(8'd7, 4'd3, 1'b0);
      chk8("r_k", 7, 1, 0, 0);
      #1 Rst = 1'b1;
      #1;
      chk8("r_async", 0, 0, 0, 0);
      Rst = 1'b0;
      step(4);
      chk8("r_idle", 0, 0, 0, 0);

      // Load coinciding with terminal count: load wins
      load8(8'd2, 4'd0, 1'b0);
      step();
      chk8("lt_k1", 1, 1, 0, 0);
      load8(8'd8, 4'd0, 1'b0);
      chk8("lt_k2", 8, 1, 0, 0);
      step();
      chk8("lt_k3", 7, 1, 0, 0);

      // 16-bit full range
      bus16.Load = 1'b1; bus16.LoadVal = 16'hFFFF; bus16.Prescale = 0; bus16.Mode = 0;
      step();
      bus16.Load = 1'b0;
      chk("w16_k", 32'(bus16.Count), 32'hFFFF);
      step();
      chk("w16_k1", 32'(bus16.Count), 32'hFFFE);
      step(65533);
      chk("w16_pre.cnt",  32'(bus16.Count), 32'd1);
      chk("w16_pre.tick", 32'(bus16.Tick),  32'd0);
      step();
      chk("w16_term.cnt",  32'(bus16.Count), 32'd0);
      chk("w16_term.tick", 32'(bus16.Tick),  32'd1);
      chk("w16_term.done", 32'(bus16.Done),  32'd1);
      step();
      chk("w16_hold.cnt",  32'(bus16.Count), 32'd0);
      chk("w16_hold.tick", 32'(bus16.Tick),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
